// File: rtl/s27_bist_pkg.sv
// s27 BIST shared types and constants.
// States, flush vectors, LFSR taps, SISR poly.
package s27_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH1,
    ST_FLUSH2,
    ST_TEST,
    ST_DONE
  } state_e;

  // Flush pair: F parks G5=1,G6=G7=0; E then clears G5.
  localparam logic [3:0] FLUSH_V1 = 4'hF;
  localparam logic [3:0] FLUSH_V2 = 4'hE;

  // x^4+x^3+1 Fibonacci taps on L[3] and L[2].
  localparam logic [3:0] LFSR_TAPS = 4'b1100;

  // x^8+x^4+x^3+x^2+1
  localparam logic [7:0] SISR_POLY = 8'h1D;

  function automatic logic [3:0] lfsr_next(
    input logic [3:0] l
  );
    return {l[2:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/s27_bist_if.sv
// s27 pin bundle between BIST and CUT.
// master drives G0..G3, slave returns G17.
interface s27_bist_if;
  logic G0;
  logic G1;
  logic G2;
  logic G3;
  logic G17;

  modport master (
    output G0,
    output G1,
    output G2,
    output G3,
    input  G17
  );

  modport slave (
    input  G0,
    input  G1,
    input  G2,
    input  G3,
    output G17
  );
endinterface

// File: rtl/s27_sisr.sv
// 8-bit serial-input signature register.
// CRC-8 form; clr wins over en.
module s27_sisr
  import s27_bist_pkg::*;
(
  input  logic       CK,
  input  logic       RST,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] sig
);

  logic [7:0] sig_q;
  logic [7:0] sig_d;
  logic       fb;

  // Next signature: clear, absorb one bit, or hold.
  always_comb begin
    fb    = sig_q[7] ^ din;
    sig_d = sig_q;
    if (clr) begin
      sig_d = 8'h00;
    end else if (en) begin
      sig_d = {sig_q[6:0], 1'b0} ^ (fb ? SISR_POLY : 8'h00);
    end
  end

  // Signature register with synchronous reset.
  always_ff @(posedge CK) begin
    if (RST) begin
      sig_q <= 8'h00;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/s27_bist.sv
// s27 BIST: flush, LFSR vectors, SISR compaction.
// Compares final signature against GOLDEN.
module s27_bist
  import s27_bist_pkg::*;
#(
  parameter int          N_PAT     = 15,
  parameter logic [3:0]  LFSR_SEED = 4'h1,
  parameter logic [7:0]  GOLDEN    = 8'h00
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              START,
  s27_bist_if.master        cut,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [7:0]        SIG
);

  localparam logic [7:0] LAST = 8'(N_PAT - 1);

  state_e     state_q, state_d;
  logic [3:0] lfsr_q, lfsr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] v_q, v_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       sisr_clr;
  logic       sisr_en;
  logic [7:0] sig;

  // Sequencer next-state, LFSR/count update, SISR control.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    sisr_clr = 1'b0;
    sisr_en  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_d  = ST_FLUSH1;
          lfsr_d   = LFSR_SEED;
          cnt_d    = 8'd0;
          sisr_clr = 1'b1;
        end
      end
      ST_FLUSH1: state_d = ST_FLUSH2;
      ST_FLUSH2: state_d = ST_TEST;
      ST_TEST: begin
        sisr_en = 1'b1;
        lfsr_d  = lfsr_next(lfsr_q);
        cnt_d   = cnt_q + 8'd1;
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs decoded from the upcoming state.
  always_comb begin
    v_d    = 4'h0;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_d)
      ST_FLUSH1: begin
        v_d    = FLUSH_V1;
        busy_d = 1'b1;
      end
      ST_FLUSH2: begin
        v_d    = FLUSH_V2;
        busy_d = 1'b1;
      end
      ST_TEST: begin
        v_d    = lfsr_d;
        busy_d = 1'b1;
      end
      ST_DONE: done_d = 1'b1;
      default: v_d = 4'h0;
    endcase
  end

  // State, LFSR, counter and output flops.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      lfsr_q  <= LFSR_SEED;
      cnt_q   <= 8'd0;
      v_q     <= 4'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  s27_sisr u_sisr (
    .CK  (CK),
    .RST (RST),
    .clr (sisr_clr),
    .en  (sisr_en),
    .din (cut.G17),
    .sig (sig)
  );

  assign cut.G0 = v_q[0];
  assign cut.G1 = v_q[1];
  assign cut.G2 = v_q[2];
  assign cut.G3 = v_q[3];
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign PASS   = done_q && (sig == GOLDEN);
  assign SIG    = sig;

endmodule

// File: tb/tb_s27_bist.sv
// Bench for s27_bist: stubbed and real s27 CUT.
// Reference signatures computed from first principles.
module tb_s27_bist;

  logic CK = 1'b0;
  logic RST;
  logic START;

  always #5 CK = ~CK;

  int n_cmp = 0;
  int n_bad = 0;

  // s27 netlist; st = {G7,G6,G5}; returns {G17, next st}.
  function automatic logic [3:0] s27_fn(
    input logic [2:0] st,
    input logic [3:0] v
  );
    logic g5, g6, g7, g8, g9, g10, g11, g12;
    logic g13, g14, g15, g16;
    g5  = st[0];
    g6  = st[1];
    g7  = st[2];
    g14 = ~v[0];
    g8  = g14 & g6;
    g12 = ~(v[1] | g7);
    g15 = g12 | g8;
    g16 = v[3] | g8;
    g9  = ~(g16 & g15);
    g11 = ~(g5 | g9);
    g10 = ~(g14 | g11);
    g13 = ~(v[2] | g12);
    return {~g11, g13, g11, g10};
  endfunction

  // Signature of a G17 bit stream, one polynomial step per bit.
  function automatic logic [7:0] sig_of(
    input logic [31:0] bits,
    input int n
  );
    logic [7:0] s;
    s = 8'h00;
    for (int k = 0; k < n; k++) begin
      s = {s[6:0], 1'b0} ^ ({8{s[7] ^ bits[k]}} & 8'h1D);
    end
    return s;
  endfunction

  // Real-CUT signature: flushed state 0, LFSR seed 1.
  function automatic logic [7:0] ref_sig_e(input int n);
    logic [2:0]  st;
    logic [3:0]  l;
    logic [3:0]  r;
    logic [31:0] b;
    st = 3'b000;
    l  = 4'h1;
    b  = '0;
    for (int k = 0; k < n; k++) begin
      r    = s27_fn(st, l);
      b[k] = r[3];
      st   = r[2:0];
      l    = {l[2:0], l[3] ^ l[2]};
    end
    return sig_of(b, n);
  endfunction

  localparam int         NP_E   = 20;
  localparam logic [7:0] GOLD_E = ref_sig_e(NP_E);

  s27_bist_if if_a ();
  s27_bist_if if_b ();
  s27_bist_if if_c ();
  s27_bist_if if_d ();
  s27_bist_if if_e ();

  logic [4:0] bsy, dn, ps;
  logic [7:0] sg [5];

  s27_bist #(.N_PAT(15), .LFSR_SEED(4'h1), .GOLDEN(8'h00)) u_a (
    .CK(CK), .RST(RST), .START(START), .cut(if_a),
    .BUSY(bsy[0]), .DONE(dn[0]), .PASS(ps[0]), .SIG(sg[0]));
  s27_bist #(.N_PAT(15), .LFSR_SEED(4'h1), .GOLDEN(8'h01)) u_b (
    .CK(CK), .RST(RST), .START(START), .cut(if_b),
    .BUSY(bsy[1]), .DONE(dn[1]), .PASS(ps[1]), .SIG(sg[1]));
  s27_bist #(.N_PAT(1), .LFSR_SEED(4'h1), .GOLDEN(8'h1D)) u_c (
    .CK(CK), .RST(RST), .START(START), .cut(if_c),
    .BUSY(bsy[2]), .DONE(dn[2]), .PASS(ps[2]), .SIG(sg[2]));
  s27_bist #(.N_PAT(2), .LFSR_SEED(4'h1), .GOLDEN(8'h00)) u_d (
    .CK(CK), .RST(RST), .START(START), .cut(if_d),
    .BUSY(bsy[3]), .DONE(dn[3]), .PASS(ps[3]), .SIG(sg[3]));
  s27_bist #(.N_PAT(NP_E), .LFSR_SEED(4'h1), .GOLDEN(GOLD_E)) u_e (
    .CK(CK), .RST(RST), .START(START), .cut(if_e),
    .BUSY(bsy[4]), .DONE(dn[4]), .PASS(ps[4]), .SIG(sg[4]));

  // Real s27 beside u_e, flops start unknown.
  logic [2:0] cut_st = 3'bxxx;
  logic [3:0] cut_r;
  assign cut_r = s27_fn(cut_st, {if_e.G3, if_e.G2, if_e.G1, if_e.G0});
  assign if_e.G17 = cut_r[3];
  always @(posedge CK) cut_st <= cut_r[2:0];

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] va();
    return {if_a.G3, if_a.G2, if_a.G1, if_a.G0};
  endfunction

  // One run on u_a with a G17 stream; optional START noise and reset.
  task automatic run_a(input logic [14:0] bits, input bit rnd,
                       input int rst_at, output logic [7:0] sig_o);
    logic [7:0] m;
    m     = sig_of({17'd0, bits}, 15);
    sig_o = 8'h00;
    START = 1'b1;
    step();
    START = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i >= 2) if_a.G17 = bits[i-2];
      START = (rnd && i < 16) ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (i == rst_at) begin
        RST   = 1'b1;
        START = 1'b0;
        step();
        RST = 1'b0;
        chk("midrst_busy", bsy[0], 1'b0);
        chk("midrst_done", dn[0], 1'b0);
        chk("midrst_sig", sg[0], 8'h00);
        chk("midrst_v", va(), 4'h0);
        return;
      end
      chk("run_busy", bsy[0], 1'b1);
      step();
    end
    chk("run_done", dn[0], 1'b1);
    chk("run_busy_end", bsy[0], 1'b0);
    chk("run_sig", sg[0], m);
    chk("run_pass", ps[0], m == 8'h00);
    sig_o = sg[0];
  endtask

  logic [3:0] exp_v [17] = '{4'hF, 4'hE, 4'h1, 4'h2, 4'h4, 4'h9,
                             4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB,
                             4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

  initial begin
    logic [14:0] bits;
    logic [7:0]  s_full, s_dummy, s_again;

    if_a.G17 = 1'b0;
    if_b.G17 = 1'b0;
    if_c.G17 = 1'b1;
    if_d.G17 = 1'b1;

    RST   = 1'b1;
    START = 1'b1;
    step();
    step();
    chk("rst_v", va(), 4'h0);
    chk("rst_busy", bsy[0], 1'b0);
    chk("rst_done", dn[0], 1'b0);
    chk("rst_pass", ps[0], 1'b0);
    chk("rst_sig", sg[0], 8'h00);
    RST   = 1'b0;
    START = 1'b0;
    step();
    chk("idle_busy", bsy[0], 1'b0);

    START = 1'b1;
    step();
    START = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (i < 17) begin
        chk($sformatf("vec%0d", i), va(), exp_v[i]);
        chk($sformatf("busy%0d", i), bsy[0], 1'b1);
        chk($sformatf("nodone%0d", i), dn[0], 1'b0);
      end else begin
        chk($sformatf("vec0_%0d", i), va(), 4'h0);
        chk($sformatf("busy_lo%0d", i), bsy[0], 1'b0);
        chk($sformatf("done_hi%0d", i), dn[0], 1'b1);
        chk($sformatf("sig0_%0d", i), sg[0], 8'h00);
        chk($sformatf("pass_a%0d", i), ps[0], 1'b1);
      end
      if (i == 17) begin
        chk("pass_b", ps[1], 1'b0);
        chk("done_b", dn[1], 1'b1);
      end
      if (i == 3) begin
        chk("c_done", dn[2], 1'b1);
        chk("c_sig", sg[2], 8'h1D);
        chk("c_pass", ps[2], 1'b1);
        if_d.G17 = 1'b0;
      end
      if (i == 4) begin
        chk("d_done", dn[3], 1'b1);
        chk("d_sig10", sg[3], 8'h3A);
      end
      if (i >= 2 && i < NP_E + 2)
        chk($sformatf("e_g17_known%0d", i), $isunknown(if_e.G17), 1'b0);
      if (i == NP_E + 2) begin
        chk("e_done", dn[4], 1'b1);
        chk("e_sig", sg[4], ref_sig_e(NP_E));
        chk("e_pass", ps[4], 1'b1);
      end
      step();
    end

    if_d.G17 = 1'b1;
    START = 1'b1;
    step();
    START = 1'b0;
    chk("restart_done_drop", dn[0], 1'b0);
    chk("restart_busy", bsy[0], 1'b1);
    for (int i = 0; i < 4; i++) step();
    chk("d_done2", dn[3], 1'b1);
    chk("d_sig11", sg[3], 8'h27);
    for (int i = 0; i < 20; i++) step();

    for (int r = 0; r < 6; r++) begin
      bits = 15'($urandom);
      run_a(bits, 1'b1, -1, s_full);
      repeat ($urandom_range(0, 3)) step();
    end

    bits = 15'($urandom);
    run_a(bits, 1'b0, -1, s_full);
    run_a(bits, 1'b0, 6, s_dummy);
    step();
    chk("post_rst_idle", bsy[0], 1'b0);
    run_a(bits, 1'b1, -1, s_again);
    chk("rerun_same_sig", s_again, s_full);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/s27_bist.md
Name: s27_bist

Overview:
- Built-in self-test driver and response compactor for the s27 sequential benchmark. It is the stimulus and observation end of the s27 pin interface.
- Drives G0..G3 and observes G17.
- The CUT has no reset, so on START the block first flushes the CUT's three flip-flops to a known state.
- It then applies N_PAT pseudo-random vectors from an LFSR, compacts G17 into a serial-input signature register (SISR), and compares the result against a golden signature.
- Sits beside s27 on the same CK.

Parameters:
- N_PAT, 15, number of test vectors applied after flush; legal range 1..255.
- LFSR_SEED, 4'h1, initial LFSR value; must be nonzero.
- GOLDEN, 8'h00, expected signature; set by the integrator from the reference model.

Ports:
- CK  in  1  clock, shared with s27.
- RST  in  1  synchronous, active-high reset.
- START  in  1  one-cycle request to run a test; sampled only in IDLE.
- G17  in  1  CUT response; combinational function of CUT state and the current G0..G3.
- G0  out  1  CUT input, bit0 of vector V.
- G1  out  1  CUT input, bit1 of V.
- G2  out  1  CUT input, bit2 of V.
- G3  out  1  CUT input, bit3 of V.
- BUSY  out  1  high from FLUSH1 through the last TEST cycle.
- DONE  out  1  high in DONE state; held until next START or RST.
- PASS  out  1  SIG==GOLDEN; valid only while DONE=1, otherwise 0.
- SIG  out  8  current signature register.

Behaviour:
- Reset: all state is synchronous; RST=1 at an edge forces the following.
  - State=IDLE, V=0, LFSR=LFSR_SEED, SIG=0, count=0.
  - BUSY=0, DONE=0, PASS=0.
  - RST has priority over START and over every state, including mid-flush and mid-test.
- Outputs: all outputs are registered or decoded from registered state.
- FSM state IDLE:
  - V=0.
  - START=1 → FLUSH1; SIG cleared to 0, LFSR←LFSR_SEED, count←0.
- FSM state FLUSH1:
  - V=4'hF (G0=G1=G2=G3=1).
  - After this edge the CUT holds G6=0, G7=0, G5=1.
  - SISR not clocked. → FLUSH2.
- FSM state FLUSH2:
  - V=4'hE (G0=0, others 1).
  - After this edge the CUT holds G5=G6=G7=0.
  - SISR not clocked. → TEST.
- FSM state TEST:
  - V=LFSR.
  - Each edge: SISR absorbs G17, LFSR advances, count++.
  - When count==N_PAT-1 at the edge → DONE.
- FSM state DONE:
  - V=0, DONE=1, PASS=(SIG==GOLDEN).
  - START=1 → FLUSH1; DONE drops the next cycle and a full new run begins.
- START in FLUSH1/FLUSH2/TEST: ignored, no restart, no error.
- Latency: START edge → first flush vector visible next cycle.
  - BUSY lasts N_PAT+2 cycles.
  - DONE rises the cycle after the last TEST vector.
- LFSR: 4-bit Fibonacci, x^4+x^3+1.
  - next = {L[2:0], L[3]^L[2]}; period 15.
  - Vector 0 is never applied.
  - N_PAT>15 wraps the sequence.
- SISR: 8-bit, CRC-8 form, polynomial 8'h1D (x^8+x^4+x^3+x^2+1).
  - fb = S[7]^G17.
  - next = (S<<1) ^ (fb ? 8'h1D : 8'h00).
- Width: count is 8 bits; no overflow within the legal N_PAT range.

Decomposition:
- Package s27_bist_pkg holds:
  - state enum {IDLE, FLUSH1, FLUSH2, TEST, DONE}
  - FLUSH_V1=4'hF, FLUSH_V2=4'hE
  - LFSR taps
  - SISR_POLY=8'h1D
- Sub-module s27_sisr: 8-bit serial signature register.
  - Ports: CK, RST, clr, en, din, sig.
  - Used by s27_bist; reusable for other single-output benchmarks.
- LFSR and FSM stay in the top.

Test Plan:
1. Reset: hold RST=1 for 2 cycles with START=1 → G0..G3=0, BUSY=0, DONE=0, PASS=0, SIG=8'h00.
2. Vector sequence (N_PAT=15, seed 1): START pulse → V = F, E, 1, 2, 4, 9, 3, 6, D, A, 5, B, 7, F, E, C, 8 on consecutive cycles. BUSY high for exactly 17 cycles. DONE rises on cycle 18 and stays high.
3. Stubbed CUT, G17 held 0, GOLDEN=8'h00 → SIG=8'h00, PASS=1. Repeat with GOLDEN=8'h01 → PASS=0.
4. SISR arithmetic, stubbed CUT:
   - N_PAT=1, G17=1 during TEST → SIG=8'h1D.
   - N_PAT=2, G17=1 then 0 → SIG=8'h3A.
   - N_PAT=2, G17=1 then 1 → SIG=8'h27.
5. Mid-operation: assert RST during the 5th TEST cycle → IDLE next cycle, SIG=0. START pulses during BUSY are ignored. A fresh START gives the same final SIG as an uninterrupted run.
6. Integrated with s27, CUT flops initialised to X → no X on G17 after FLUSH2. Final SIG equals the bench reference-model signature, and PASS=1 when GOLDEN is set to it.
